// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator BCD display path.
// Holds the digit type, converter FSM states and the leading-zero helper.
package calc_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned MAX_VAL = 99999999;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Bit i set when digit i and every digit above it are zero; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [BCD_W-1:0] bcd);
    logic [NUM_DIGITS-1:0] mask;
    logic seen;
    mask = '0;
    seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (bcd[4*i +: 4] != 4'd0) seen = 1'b1;
      mask[i] = !seen;
    end
    return mask;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: adds 3 to any digit of 5 or more before the shift.
// Purely combinational, zero latency, no flow control.
module bcd_add3
  import calc_pkg::*;
(
  input  bcd_t d,
  output bcd_t q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) q = d + 4'd3;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3); result valid WIDTH+1 edges after start.
// start is taken only in IDLE (ignored while busy); optional blank output under BIN2BCD_BLANK_EN.
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output bcd_t             num0,
  output bcd_t             num1,
  output bcd_t             num2,
  output bcd_t             num3,
  output bcd_t             num4,
  output bcd_t             num5,
  output bcd_t             num6,
  output bcd_t             num7
`ifdef BIN2BCD_BLANK_EN
  ,
  output logic [7:0]       blank
`endif
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int SR_W  = BCD_W + WIDTH;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  state_t state, state_nx;

  logic [SR_W-1:0]  sr, sr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             ovf_pend, ovf_pend_nx;
  logic             busy_nx, done_nx, ovf_nx;
  logic [BCD_W-1:0] num_q, num_nx;
  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  sr_shifted;

`ifdef BIN2BCD_BLANK_EN
  logic [7:0] blank_q, blank_nx;
`endif

  // Eight parallel digit corrections on the BCD field, then one left shift of the whole register.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (sr[WIDTH + 4*g +: 4]),
      .q (bcd_adj[4*g +: 4])
    );
  end

  assign sr_shifted = {bcd_adj[BCD_W-2:0], sr[WIDTH-1:0], 1'b0};

  always_comb begin
    state_nx    = state;
    sr_nx       = sr;
    cnt_nx      = cnt;
    ovf_pend_nx = ovf_pend;
    busy_nx     = busy;
    done_nx     = 1'b0;
    ovf_nx      = ovf;
    num_nx      = num_q;
`ifdef BIN2BCD_BLANK_EN
    blank_nx    = blank_q;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          sr_nx       = {{BCD_W{1'b0}}, bin};
          cnt_nx      = CNT_W'(WIDTH);
          ovf_pend_nx = (bin > MAX_W);
          busy_nx     = 1'b1;
          state_nx    = SHIFT;
        end
      end
      SHIFT: begin
        sr_nx  = sr_shifted;
        cnt_nx = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nx = FINISH;
      end
      FINISH: begin
        // Out-of-range values show as all nines; the digit field may hold garbage then.
        num_nx   = ovf_pend ? {NUM_DIGITS{4'h9}} : sr[SR_W-1 -: BCD_W];
        ovf_nx   = ovf_pend;
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = IDLE;
`ifdef BIN2BCD_BLANK_EN
        blank_nx = ovf_pend ? 8'h00 : lead_zero_mask(sr[SR_W-1 -: BCD_W]);
`endif
      end
      default: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      num_q    <= '0;
`ifdef BIN2BCD_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      state    <= state_nx;
      sr       <= sr_nx;
      cnt      <= cnt_nx;
      ovf_pend <= ovf_pend_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      ovf      <= ovf_nx;
      num_q    <= num_nx;
`ifdef BIN2BCD_BLANK_EN
      blank_q  <= blank_nx;
`endif
    end
  end

  assign num0 = num_q[3:0];
  assign num1 = num_q[7:4];
  assign num2 = num_q[11:8];
  assign num3 = num_q[15:12];
  assign num4 = num_q[19:16];
  assign num5 = num_q[23:20];
  assign num6 = num_q[27:24];
  assign num7 = num_q[31:28];

`ifdef BIN2BCD_BLANK_EN
  assign blank = blank_q;
`endif

endmodule
